// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a show-ahead receive FIFO.
// Bytes are sampled at the bit centre from a 2-flop synchronised copy of uart_RX.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               uart_RX,
    output logic                               rx_valid,
    input  logic                               rx_ready,
    output logic [7:0]                         rx_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    rx_count,
    output logic                               frame_err,
    output logic                               overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                               parity_err
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd4,
`endif
        ST_STOP      = 3'd5
    } state_t;

    state_t            state_q;
    logic              rx_meta_q;
    logic              rxs_q;
    logic [1:0]        sync_fill_q;
    logic [TMR_W-1:0]  timer_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic              frame_err_q;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              rx_valid_q;
    logic [7:0]        rx_data_q;
    logic              overrun_q;

    logic              stop_sample_s;
    logic              byte_ok_s;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              wr_ok_s;
    logic              drop_s;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [CNT_W-1:0]  count_d;
    logic [7:0]        rx_data_d;

`ifdef UART_RX_PARITY_EN
    logic              par_bit_q;
    logic              parity_err_q;

    // Even parity: the received parity bit must equal the XOR of the data bits.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    // Two-flop synchroniser; sync_fill_q marks when rxs_q holds a real line sample rather than its reset value.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            sync_fill_q <= 2'b00;
        end else begin
            rx_meta_q   <= uart_RX;
            rxs_q       <= rx_meta_q;
            sync_fill_q <= {sync_fill_q[0], 1'b1};
        end
    end

    // Receive FSM: bit timing, deserialisation and frame-error reporting.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_WAIT_IDLE;
            timer_q      <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                ST_WAIT_IDLE: begin
                    timer_q <= '0;
                    if (sync_fill_q[1] && rxs_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    timer_q <= '0;
                    if (!rxs_q) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (timer_q == HALF_LAST) begin
                        timer_q   <= '0;
                        bit_idx_q <= 3'd0;
                        state_q   <= rxs_q ? ST_IDLE : ST_DATA;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_DATA: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q   <= '0;
                        shift_q   <= {rxs_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q   <= '0;
                        par_bit_q <= rxs_q;
                        state_q   <= ST_STOP;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q <= '0;
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= (even_parity(shift_q) != par_bit_q);
`endif
                        if (rxs_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_WAIT_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    timer_q <= '0;
                    state_q <= ST_WAIT_IDLE;
                end
            endcase
        end
    end

    // Push/pop decisions and next FIFO state, including the show-ahead head byte.
    always_comb begin
        stop_sample_s = (state_q == ST_STOP) && (timer_q == BIT_LAST);
`ifdef UART_RX_PARITY_EN
        byte_ok_s     = rxs_q && (even_parity(shift_q) == par_bit_q);
`else
        byte_ok_s     = rxs_q;
`endif
        push_s        = stop_sample_s && byte_ok_s;
        pop_s         = rx_valid_q && rx_ready;
        full_s        = (count_q == CNT_FULL);
        wr_ok_s       = push_s && (!full_s || pop_s);
        drop_s        = push_s && full_s && !pop_s;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // The byte written this cycle is not yet in memory, so bypass it when it becomes the head.
        rx_data_d = rx_data_q;
        if (count_d == '0) begin
            rx_data_d = rx_data_q;
        end else if (count_q == '0 || (count_q == CNT_W'(1) && pop_s)) begin
            rx_data_d = shift_q;
        end else begin
            rx_data_d = mem_q[rd_ptr_d];
        end
    end

    // FIFO storage array.
    always_ff @(posedge clock) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // FIFO pointers, occupancy and registered consumer-side outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            overrun_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rx_valid_q <= (count_d != '0);
            rx_data_q  <= rx_data_d;
            overrun_q  <= drop_s;
        end
    end

    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign rx_count   = count_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: serial frames driven bit by bit, delivered bytes compared to a queue model.
module tb_uart_rx_fifo;

    localparam int CLKS  = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Cycles from frame start to the edge where the stop bit is sampled (stop-bit centre + sync + register).
    localparam int LAT = (NBITS - 1) * CLKS + CLKS / 2 + 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       uart_RX = 1'b1;
    logic       rx_ready = 1'b0;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [2:0] rx_count;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_start = 0;
    int rise_cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    int both_cnt = 0;
    logic valid_prev = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.CLKS_PER_BIT(CLKS), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .uart_RX(uart_RX),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .rx_count(rx_count),
        .frame_err(frame_err),
        .overrun(overrun)
`ifdef UART_RX_PARITY_EN
        ,.parity_err(parity_err)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: records popped bytes, pulse counts and rx_valid rise times on the falling edge.
    always @(negedge clock) begin
        valid_prev <= rx_valid;
        if (rx_valid && !valid_prev) rise_cyc <= cyc;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (frame_err && overrun) both_cnt <= both_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pe_cnt <= pe_cnt + 1;
`endif
    end

    // mode: 0 plain, 1 rx_ready pulse in stop-sample cycle, 2 reset mid-DATA, 3 random rx_ready
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip, input int mode);
        logic fb [NBITS];
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1 + i] = b[i];
`ifdef UART_RX_PARITY_EN
        fb[9] = (^b) ^ par_flip;
`endif
        fb[NBITS - 1] = stop_bit;
        for (int t = 0; t < NBITS * CLKS; t++) begin
            @(posedge clock); #1;
            if (t == 0) last_start = cyc;
            uart_RX = fb[t / CLKS];
            if (mode == 1 && t == LAT - 1) rx_ready = 1'b1;
            if (mode == 1 && t == LAT) rx_ready = 1'b0;
            if (mode == 2 && t == 3 * CLKS) reset = 1'b1;
            if (mode == 2 && t == 8 * CLKS + 2) reset = 1'b0;
            if (mode == 3) rx_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clock); #1;
        uart_RX = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        int k;
        rx_ready = 1'b1;
        k = 0;
        while (rx_valid && k < 200) begin
            @(posedge clock); #1;
            k++;
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_drain_timeout rx_valid=%b required 0", name, rx_valid);
        end
        idle(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        uart_RX = 1'b1;
        rx_ready = 1'b0;
        idle(5);
        reset = 1'b0;
        idle(1);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        checks++; if (rx_count !== 3'd0) begin failures++; $display("FAIL reset_rx_count got %0d want 0", rx_count); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got %b want 0", overrun); end
`ifdef UART_RX_PARITY_EN
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
`endif
        idle(4);
    endtask

    task automatic test_basic();
        int base = got_q.size();
        int fe0 = fe_cnt;
        logic [7:0] bytes [2];
        bytes[0] = 8'hA5;
        bytes[1] = 8'h3C;
        rx_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send_frame(bytes[i], 1'b1, 1'b0, 0);
            checks++;
            if (rise_cyc - last_start !== LAT) begin
                failures++;
                $display("FAIL basic_latency%0d got %0d want %0d", i, rise_cyc - last_start, LAT);
            end
            idle(CLKS);
        end
        checks++;
        if (got_q.size() - base !== 2) begin
            failures++;
            $display("FAIL basic_pop_count got %0d want 2", got_q.size() - base);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_q[base + i] !== bytes[i]) begin
                    failures++;
                    $display("FAIL basic_byte%0d got %h want %h", i, got_q[base + i], bytes[i]);
                end
            end
        end
        checks++; if (fe_cnt - fe0 !== 0) begin failures++; $display("FAIL basic_frame_err got %0d want 0", fe_cnt - fe0); end
    endtask

    task automatic test_glitch();
        int base = got_q.size();
        int fe0 = fe_cnt;
        int ov0 = ov_cnt;
        rx_ready = 1'b1;
        uart_RX = 1'b0;
        idle(4);
        uart_RX = 1'b1;
        idle(NBITS * CLKS * 2);
        checks++; if (got_q.size() - base !== 0) begin failures++; $display("FAIL glitch_bytes got %0d want 0", got_q.size() - base); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL glitch_rx_valid got %b want 0", rx_valid); end
        checks++; if (fe_cnt - fe0 + ov_cnt - ov0 !== 0) begin failures++; $display("FAIL glitch_pulses got %0d want 0", fe_cnt - fe0 + ov_cnt - ov0); end
    endtask

    task automatic test_frame_err();
        int base = got_q.size();
        int fe0 = fe_cnt;
        rx_ready = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0, 0);
        idle(3 * CLKS);
        checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL ferr_pulses got %0d want 1", fe_cnt - fe0); end
        checks++; if (rx_count !== 3'd0) begin failures++; $display("FAIL ferr_rx_count got %0d want 0", rx_count); end
        rx_ready = 1'b1;
        send_frame(8'h12, 1'b1, 1'b0, 0);
        idle(CLKS);
        checks++;
        if (got_q.size() - base !== 1) begin
            failures++;
            $display("FAIL ferr_next_count got %0d want 1", got_q.size() - base);
        end else if (got_q[base] !== 8'h12) begin
            failures++;
            $display("FAIL ferr_next_byte got %h want 12", got_q[base]);
        end
        checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL ferr_after_next got %0d want 1", fe_cnt - fe0); end
    endtask

    task automatic test_overrun();
        int base = got_q.size();
        int ov0 = ov_cnt;
        int fe0 = fe_cnt;
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 0);
            idle(4);
        end
        checks++; if (rx_count !== 3'd4) begin failures++; $display("FAIL ovr_rx_count got %0d want 4", rx_count); end
        checks++; if (ov_cnt - ov0 !== 1) begin failures++; $display("FAIL ovr_pulses got %0d want 1", ov_cnt - ov0); end
        checks++; if (fe_cnt - fe0 !== 0) begin failures++; $display("FAIL ovr_frame_err got %0d want 0", fe_cnt - fe0); end
        drain("ovr");
        checks++;
        if (got_q.size() - base !== 4) begin
            failures++;
            $display("FAIL ovr_drain_count got %0d want 4", got_q.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[base + i] !== 8'(i + 1)) begin
                    failures++;
                    $display("FAIL ovr_byte%0d got %h want %h", i, got_q[base + i], 8'(i + 1));
                end
            end
        end
        checks++; if (rx_count !== 3'd0) begin failures++; $display("FAIL ovr_empty got %0d want 0", rx_count); end
    endtask

    task automatic test_full_push_pop();
        int base = got_q.size();
        int ov0 = ov_cnt;
        exp_q.delete();
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'($urandom_range(0, 255)));
            send_frame(exp_q[i], 1'b1, 1'b0, 0);
            idle(2);
        end
        exp_q.push_back(8'h05);
        send_frame(8'h05, 1'b1, 1'b0, 1);
        idle(4);
        checks++; if (rx_count !== 3'd4) begin failures++; $display("FAIL fullpp_rx_count got %0d want 4", rx_count); end
        checks++; if (ov_cnt - ov0 !== 0) begin failures++; $display("FAIL fullpp_overrun got %0d want 0", ov_cnt - ov0); end
        drain("fullpp");
        checks++;
        if (got_q.size() - base !== 5) begin
            failures++;
            $display("FAIL fullpp_count got %0d want 5", got_q.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got_q[base + i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL fullpp_byte%0d got %h want %h", i, got_q[base + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int base = got_q.size();
        int fe0 = fe_cnt;
        int ov0 = ov_cnt;
        int pe0 = pe_cnt;
        rx_ready = 1'b1;
        send_frame(8'h7E, 1'b1, 1'b0, 2);
        idle(3 * CLKS);
        checks++; if (got_q.size() - base !== 0) begin failures++; $display("FAIL rstmid_bytes got %0d want 0", got_q.size() - base); end
        checks++;
        if (fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0 !== 0) begin
            failures++;
            $display("FAIL rstmid_pulses got %0d want 0", fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0);
        end
        send_frame(8'h81, 1'b1, 1'b0, 0);
        idle(CLKS);
        checks++;
        if (got_q.size() - base !== 1) begin
            failures++;
            $display("FAIL rstmid_next_count got %0d want 1", got_q.size() - base);
        end else if (got_q[base] !== 8'h81) begin
            failures++;
            $display("FAIL rstmid_next_byte got %h want 81", got_q[base]);
        end
    endtask

    task automatic test_random();
        int base = got_q.size();
        int fe0 = fe_cnt;
        int ov0 = ov_cnt;
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(8'($urandom_range(0, 255)));
            send_frame(exp_q[i], 1'b1, 1'b0, 3);
            for (int g = 0; g < int'($urandom_range(0, 20)); g++) begin
                @(posedge clock); #1;
                rx_ready = 1'($urandom_range(0, 1));
            end
        end
        drain("rand");
        checks++;
        if (got_q.size() - base !== 12) begin
            failures++;
            $display("FAIL rand_count got %0d want 12", got_q.size() - base);
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (got_q[base + i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand_byte%0d got %h want %h", i, got_q[base + i], exp_q[i]);
                end
            end
        end
        checks++; if (fe_cnt - fe0 + ov_cnt - ov0 !== 0) begin failures++; $display("FAIL rand_pulses got %0d want 0", fe_cnt - fe0 + ov_cnt - ov0); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int base = got_q.size();
        int pe0 = pe_cnt;
        rx_ready = 1'b1;
        send_frame(8'h03, 1'b1, 1'b1, 0);
        idle(CLKS);
        checks++; if (pe_cnt - pe0 !== 1) begin failures++; $display("FAIL parity_bad_pulse got %0d want 1", pe_cnt - pe0); end
        checks++; if (got_q.size() - base !== 0) begin failures++; $display("FAIL parity_bad_pushed got %0d want 0", got_q.size() - base); end
        send_frame(8'h03, 1'b1, 1'b0, 0);
        idle(CLKS);
        checks++; if (pe_cnt - pe0 !== 1) begin failures++; $display("FAIL parity_good_pulse got %0d want 1", pe_cnt - pe0); end
        checks++;
        if (got_q.size() - base !== 1) begin
            failures++;
            $display("FAIL parity_good_count got %0d want 1", got_q.size() - base);
        end else if (got_q[base] !== 8'h03) begin
            failures++;
            $display("FAIL parity_good_byte got %h want 03", got_q[base]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_push_pop();
        test_reset_mid_frame();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (both_cnt !== 0) begin
            failures++;
            $display("FAIL ferr_overrun_same_cycle got %0d want 0", both_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
